// File: rtl/quat_integrator.sv
// quat_integrator: integrates q <= q (x) dq (Hamilton product, Q15)
// over one shared multiplier, sequenced by a small FSM.
//
// Ports:
//   clk        rising-edge clock
//   rst        async active-low reset
//   init       sync reload of identity quaternion (top priority)
//   in_valid   dq0..dq3 valid; accepted when in_ready
//   in_ready   IDLE and no init this cycle (combinational)
//   dq0..dq3   signed Q15 delta quaternion
//   q0..q3     signed Q15 orientation (registered)
//   out_valid  one-cycle pulse when q0..q3 update
//   busy       FSM not in IDLE
//
// Build option: define QUAT_RENORM_EN to append a first-order
// renormalisation pass (NORM_SQ, NORM_SCALE) after write-back.

module quat_integrator #(
  parameter int ACC_W   = 34,
  parameter int FRAC    = 15,
  parameter int INIT_Q0 = 32767
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               init,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [15:0] dq0,
  input  logic signed [15:0] dq1,
  input  logic signed [15:0] dq2,
  input  logic signed [15:0] dq3,
  output logic signed [15:0] q0,
  output logic signed [15:0] q1,
  output logic signed [15:0] q2,
  output logic signed [15:0] q3,
  output logic               out_valid,
  output logic               busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAC,
    S_WB,
    S_NSQ,
    S_NSC
  } state_t;

  localparam logic signed [ACC_W-1:0] HALF =
    ACC_W'(1) << (FRAC - 1);
  localparam logic signed [ACC_W-1:0] QMAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] QMIN = -QMAX;
  localparam logic signed [15:0] Q0_INIT = 16'(INIT_Q0);

  // Subtract flags for the 16 MAC terms, bit = index.
  // r0: - - - at j=1..3, r1: j=3, r2: j=1, r3: j=2.
  localparam logic [15:0] SUBMASK = 16'h428E;

  state_t state;
  logic [3:0] idx;

  logic signed [15:0]      a   [4];
  logic signed [15:0]      b   [4];
  logic signed [15:0]      qr  [4];
  logic signed [ACC_W-1:0] acc [4];

  logic [1:0] k;
  logic [1:0] j;
  logic [1:0] bsel;
  logic       sub;

  logic signed [15:0]      ma;
  logic signed [16:0]      mb;
  logic signed [32:0]      prod;
  logic signed [ACC_W-1:0] pext;

  assign k    = idx[3:2];
  assign j    = idx[1:0];
  // term j of component k pairs a_j with b_(j xor k)
  assign bsel = j ^ k;

  function automatic logic signed [15:0] rsat(
    input logic signed [ACC_W-1:0] v
  );
    logic signed [ACC_W-1:0] r;
    r = (v + HALF) >>> FRAC;
    if (r > QMAX)
      rsat = 16'sd32767;
    else if (r < QMIN)
      rsat = -16'sd32767;
    else
      rsat = r[15:0];
  endfunction

`ifdef QUAT_RENORM_EN
  localparam logic signed [ACC_W-1:0] THREE =
    ACC_W'(3) << FRAC;

  logic signed [ACC_W-1:0] nsq;
  logic signed [16:0]      s;

  // acc[0] holds the sum of squares during NORM_SCALE
  assign nsq = acc[0] >>> FRAC;
  assign s   = 17'((THREE - nsq) >>> 1);
`endif

  always_comb begin
    ma  = a[j];
    mb  = 17'(b[bsel]);
    sub = SUBMASK[idx];
`ifdef QUAT_RENORM_EN
    if (state == S_NSQ) begin
      ma = qr[j];
      mb = 17'(qr[j]);
    end else if (state == S_NSC) begin
      ma = qr[j];
      mb = s;
    end
`endif
  end

  assign prod = 33'(ma) * 33'(mb);
  assign pext = ACC_W'(prod);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      out_valid <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        a[i]   <= '0;
        b[i]   <= '0;
        acc[i] <= '0;
        qr[i]  <= (i == 0) ? Q0_INIT : '0;
      end
    end else if (init) begin
      state     <= S_IDLE;
      idx       <= '0;
      out_valid <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        acc[i] <= '0;
        qr[i]  <= (i == 0) ? Q0_INIT : '0;
      end
    end else begin
      out_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            a[0]  <= qr[0];
            a[1]  <= qr[1];
            a[2]  <= qr[2];
            a[3]  <= qr[3];
            b[0]  <= dq0;
            b[1]  <= dq1;
            b[2]  <= dq2;
            b[3]  <= dq3;
            idx   <= '0;
            state <= S_MAC;
            for (int i = 0; i < 4; i++)
              acc[i] <= '0;
          end
        end
        S_MAC: begin
          if (sub)
            acc[k] <= acc[k] - pext;
          else
            acc[k] <= acc[k] + pext;
          idx <= idx + 4'd1;
          if (idx == 4'd15)
            state <= S_WB;
        end
        S_WB: begin
          for (int i = 0; i < 4; i++) begin
            qr[i]  <= rsat(acc[i]);
            acc[i] <= '0;
          end
          idx <= '0;
`ifdef QUAT_RENORM_EN
          state <= S_NSQ;
`else
          out_valid <= 1'b1;
          state     <= S_IDLE;
`endif
        end
`ifdef QUAT_RENORM_EN
        S_NSQ: begin
          acc[0] <= acc[0] + pext;
          idx    <= idx + 4'd1;
          if (j == 2'd3) begin
            idx   <= '0;
            state <= S_NSC;
          end
        end
        S_NSC: begin
          qr[j] <= rsat(pext);
          idx   <= idx + 4'd1;
          if (j == 2'd3) begin
            idx       <= '0;
            out_valid <= 1'b1;
            state     <= S_IDLE;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_ready = (state == S_IDLE) && !init;
  assign busy     = (state != S_IDLE);

  assign q0 = qr[0];
  assign q1 = qr[1];
  assign q2 = qr[2];
  assign q3 = qr[3];

endmodule
